// File: rtl/demux.sv
// Registered 1-to-N demultiplexer: routes d onto lane s of y, one clock after sampling.
// Build option: define DEMUX_HOLD_EN to keep non-selected lanes instead of zeroing them.
module demux #(
    parameter int SEL_W  = 2,
    parameter int DATA_W = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [DATA_W-1:0]             d,
    input  logic [SEL_W-1:0]              s,
    output logic [(2**SEL_W)*DATA_W-1:0]  y,
    output logic                          vld
);

    localparam int N_OUT = 2**SEL_W;

    logic [N_OUT*DATA_W-1:0] y_q;
    logic [N_OUT*DATA_W-1:0] y_d;
    logic                    vld_q;
    logic                    vld_d;

    // Next-state: steer d to the selected lane; other lanes are zeroed or kept per build.
    always_comb begin
        y_d   = y_q;
        vld_d = vld_q;
        if (en) begin
            vld_d = 1'b1;
            for (int k = 0; k < N_OUT; k++) begin
                if (s == SEL_W'(k)) begin
                    y_d[k*DATA_W +: DATA_W] = d;
                end else begin
`ifdef DEMUX_HOLD_EN
                    y_d[k*DATA_W +: DATA_W] = y_q[k*DATA_W +: DATA_W];
`else
                    y_d[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
`endif
                end
            end
        end else begin
            y_d   = y_q;
            vld_d = vld_q;
        end
    end

    // Output registers with synchronous active-low reset taking priority over en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q   <= {(N_OUT*DATA_W){1'b0}};
            vld_q <= 1'b0;
        end else begin
            y_q   <= y_d;
            vld_q <= vld_d;
        end
    end

    assign y   = y_q;
    assign vld = vld_q;

endmodule

// File: tb/tb_demux.sv
// Self-checking bench for demux: directed steps plus random traffic against a lane-array model.
// Honours DEMUX_HOLD_EN the same way the design does.
module tb_demux;

    localparam int SEL_W  = 2;
    localparam int DATA_W = 1;
    localparam int N_OUT  = 2**SEL_W;
    localparam int YW     = N_OUT*DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [DATA_W-1:0] d;
    logic [SEL_W-1:0]  s;
    logic [YW-1:0]     y;
    logic              vld;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state kept as an array of lanes.
    logic [DATA_W-1:0] lane_m [N_OUT];
    logic              vld_m;

    demux #(.SEL_W(SEL_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .d     (d),
        .s     (s),
        .y     (y),
        .vld   (vld)
    );

    always #5 clk = ~clk;

    function automatic logic [YW-1:0] model_y();
        logic [YW-1:0] r;
        r = '0;
        for (int k = 0; k < N_OUT; k++) r = r | (YW'(lane_m[k]) << (k*DATA_W));
        return r;
    endfunction

    task automatic chk_y(input string tag, input logic [YW-1:0] exp);
        vectors++;
        assert (y === exp) else begin
            miscompares++;
            $error("FAIL %s: y=%b expected %b", tag, y, exp);
        end
    endtask

    task automatic chk_vld(input string tag, input logic exp);
        vectors++;
        assert (vld === exp) else begin
            miscompares++;
            $error("FAIL %s: vld=%b expected %b", tag, vld, exp);
        end
    endtask

    // Apply one clock of inputs, advance the model, then compare against it.
    task automatic step(input logic r, input logic e, input logic [DATA_W-1:0] dv,
                        input logic [SEL_W-1:0] sv, input string tag);
        rst_n = r; en = e; d = dv; s = sv;
        @(posedge clk);
        if (!r) begin
            for (int k = 0; k < N_OUT; k++) lane_m[k] = '0;
            vld_m = 1'b0;
        end else if (e) begin
            for (int k = 0; k < N_OUT; k++) begin
`ifdef DEMUX_HOLD_EN
                if (k == int'(sv)) lane_m[k] = dv;
`else
                lane_m[k] = (k == int'(sv)) ? dv : '0;
`endif
            end
            vld_m = 1'b1;
        end else begin
            vld_m = vld_m;
        end
        #1;
        chk_y({tag, ".y"}, model_y());
        chk_vld({tag, ".vld"}, vld_m);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; d = '0; s = '0;
        for (int k = 0; k < N_OUT; k++) lane_m[k] = '0;
        vld_m = 1'b0;

        step(1'b0, 1'b1, 1'b1, 2'd2, "reset0");
        step(1'b0, 1'b1, 1'b1, 2'd2, "reset1");
        chk_y("reset_const", 4'b0000);
        chk_vld("reset_const_vld", 1'b0);

        step(1'b1, 1'b1, 1'b1, 2'd0, "sweep0");
`ifndef DEMUX_HOLD_EN
        chk_y("sweep0_const", 4'b0001);
`endif
        step(1'b1, 1'b1, 1'b1, 2'd1, "sweep1");
`ifndef DEMUX_HOLD_EN
        chk_y("sweep1_const", 4'b0010);
`endif
        step(1'b1, 1'b1, 1'b1, 2'd2, "sweep2");
`ifndef DEMUX_HOLD_EN
        chk_y("sweep2_const", 4'b0100);
`endif
        step(1'b1, 1'b1, 1'b1, 2'd3, "sweep3");
`ifndef DEMUX_HOLD_EN
        chk_y("sweep3_const", 4'b1000);
`endif
        chk_vld("sweep_vld", 1'b1);

        step(1'b1, 1'b1, 1'b0, 2'd3, "zero_data");
`ifndef DEMUX_HOLD_EN
        chk_y("zero_data_const", 4'b0000);
`endif
        chk_vld("zero_data_vld", 1'b1);

        step(1'b1, 1'b1, 1'b1, 2'd2, "hold_setup");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 2'd0, "en_hold");
`ifndef DEMUX_HOLD_EN
        chk_y("en_hold_const", 4'b0100);
`endif

        step(1'b1, 1'b1, 1'b1, 2'd1, "midrst_setup");
        step(1'b0, 1'b1, 1'b1, 2'd3, "midrst");
        chk_y("midrst_const", 4'b0000);
        chk_vld("midrst_const_vld", 1'b0);
        step(1'b1, 1'b1, 1'b1, 2'd1, "resume");
        chk_y("resume_const", 4'b0010);

`ifdef DEMUX_HOLD_EN
        step(1'b0, 1'b0, 1'b0, 2'd0, "hold_rst");
        step(1'b1, 1'b1, 1'b1, 2'd0, "hold_a");
        chk_y("hold_a_const", 4'b0001);
        step(1'b1, 1'b1, 1'b1, 2'd2, "hold_b");
        chk_y("hold_b_const", 4'b0101);
        step(1'b1, 1'b1, 1'b0, 2'd0, "hold_c");
        chk_y("hold_c_const", 4'b0100);
`endif

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 DATA_W'($urandom),
                 SEL_W'($urandom),
                 "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
